// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Forwarding and load-use hazard unit for a 5-stage RISC-V pipeline. It sits
// beside the ID/EX stage:
//   - Per source operand of the instruction in EX, it selects the operand
//     source: the register file, the EX/MEM result or the MEM/WB result.
//   - It detects a load in EX whose destination is read by the instruction in
//     ID. When it finds one, it holds PC and IF/ID and injects bubbles into
//     ID/EX for exactly LOAD_LAT cycles.
//
// Parameters
//   NUM_SRC    : source operands per instruction (2 = rs1/rs2, 3 adds rs3)
//   REG_ADDR_W : register address width
//   LOAD_LAT   : stall cycles per load-use hazard (1..15)
//
// Ports
//   clk             in   clock
//   rst             in   synchronous reset, active-high
//   rs_id           in   source regs of ID instruction, operand i at [i*W +: W]
//   rs_ex           in   source regs of EX instruction, same packing
//   rd_id_ex        in   destination reg of the instruction in EX
//   memread_id_ex   in   instruction in EX is a load
//   rd_ex_mem       in   destination reg in EX/MEM
//   regwrite_ex_mem in   EX/MEM writes the register file
//   rd_mem_wb       in   destination reg in MEM/WB
//   regwrite_mem_wb in   MEM/WB writes the register file
//   flush           in   branch/jump redirect, aborts any stall
//   forward         out  2 bits per operand: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_pc        out  hold PC
//   stall_if_id     out  hold IF/ID
//   bubble_id_ex    out  load a NOP into ID/EX
//   stall_cycles    out  count of stalled cycles (optional feature)
//
// Optional feature
//   HAZARD_STALL_CNT_EN : when defined, stall_cycles is a saturating 32-bit
//                         counter of cycles with stall_pc=1. When undefined,
//                         stall_cycles is tied to zero and no counter exists.
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_id,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ex,
    input  logic [REG_ADDR_W-1:0]         rd_id_ex,
    input  logic                          memread_id_ex,
    input  logic [REG_ADDR_W-1:0]         rd_ex_mem,
    input  logic                          regwrite_ex_mem,
    input  logic [REG_ADDR_W-1:0]         rd_mem_wb,
    input  logic                          regwrite_mem_wb,
    input  logic                          flush,
    output logic [2*NUM_SRC-1:0]          forward,
    output logic                          stall_pc,
    output logic                          stall_if_id,
    output logic                          bubble_id_ex,
    output logic [31:0]                   stall_cycles
);

    localparam int W = REG_ADDR_W;

    // Remaining stall cycles loaded when leaving IDLE.
    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXM = 2'b01;
    localparam logic [1:0] FWD_MWB = 2'b10;

    // -------------------------------------------------------------------------
    // Forwarding
    // -------------------------------------------------------------------------
    // x0 is hardwired to zero, so a write to it is never a valid source.
    logic exm_valid;
    logic mwb_valid;

    assign exm_valid = regwrite_ex_mem && (rd_ex_mem != '0);
    assign mwb_valid = regwrite_mem_wb && (rd_mem_wb != '0);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
        logic [W-1:0] rs;
        logic [1:0]   sel;

        assign rs = rs_ex[i*W +: W];

        // EX/MEM holds the younger result, so it wins over MEM/WB.
        always_comb begin
            sel = FWD_RF;
            if (exm_valid && (rd_ex_mem == rs)) begin
                sel = FWD_EXM;
            end else if (mwb_valid && (rd_mem_wb == rs)) begin
                sel = FWD_MWB;
            end
        end

        assign forward[2*i +: 2] = sel;
    end

    // -------------------------------------------------------------------------
    // Load-use hazard detection
    // -------------------------------------------------------------------------
    logic rs_match;
    logic hz;

    always_comb begin
        rs_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_id[i*W +: W] == rd_id_ex) begin
                rs_match = 1'b1;
            end
        end
    end

    assign hz = memread_id_ex && (rd_id_ex != '0) && rs_match;

    // -------------------------------------------------------------------------
    // Stall FSM
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       stall;

    // The first stall cycle is the one in which the hazard is seen in IDLE,
    // so STALL only covers the remaining LOAD_LAT-1 cycles. Hazards seen in
    // STALL are ignored: the window length is fixed per hazard.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (hz) begin
                        stall = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = LAT_M1;
                        end
                    end
                end
                ST_STALL: begin
                    stall = 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset must kill a stall in the same cycle, hence the combinational gate.
    assign stall_pc     = stall && !rst;
    assign stall_if_id  = stall && !rst;
    assign bubble_id_ex = stall && !rst;

    // -------------------------------------------------------------------------
    // Stall cycle counter
    // -------------------------------------------------------------------------
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
        end else if (stall_pc && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int NS = 2;
    localparam int W  = 5;

`ifdef HAZARD_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [NS*W-1:0] rs_id;
    logic [NS*W-1:0] rs_ex;
    logic [W-1:0]    rd_id_ex;
    logic            memread_id_ex;
    logic [W-1:0]    rd_ex_mem;
    logic            regwrite_ex_mem;
    logic [W-1:0]    rd_mem_wb;
    logic            regwrite_mem_wb;
    logic            flush;

    logic [2*NS-1:0] fwd1, fwd3;
    logic            spc1, sif1, bub1;
    logic            spc3, sif3, bub3;
    logic [31:0]     cnt1, cnt3;

    logic [2:0]      st1, st3;
    assign st1 = {spc1, sif1, bub1};
    assign st3 = {spc3, sif3, bub3};

    int n_checks = 0;
    int n_fail   = 0;

    hazard_forward_unit #(.NUM_SRC(NS), .REG_ADDR_W(W), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rs_ex(rs_ex),
        .rd_id_ex(rd_id_ex), .memread_id_ex(memread_id_ex),
        .rd_ex_mem(rd_ex_mem), .regwrite_ex_mem(regwrite_ex_mem),
        .rd_mem_wb(rd_mem_wb), .regwrite_mem_wb(regwrite_mem_wb),
        .flush(flush), .forward(fwd1), .stall_pc(spc1), .stall_if_id(sif1),
        .bubble_id_ex(bub1), .stall_cycles(cnt1)
    );

    hazard_forward_unit #(.NUM_SRC(NS), .REG_ADDR_W(W), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rs_ex(rs_ex),
        .rd_id_ex(rd_id_ex), .memread_id_ex(memread_id_ex),
        .rd_ex_mem(rd_ex_mem), .regwrite_ex_mem(regwrite_ex_mem),
        .rd_mem_wb(rd_mem_wb), .regwrite_mem_wb(regwrite_mem_wb),
        .flush(flush), .forward(fwd3), .stall_pc(spc3), .stall_if_id(sif3),
        .bubble_id_ex(bub3), .stall_cycles(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 2 units later, well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_id           = '0;
        rs_ex           = '0;
        rd_id_ex        = '0;
        memread_id_ex   = 1'b0;
        rd_ex_mem       = '0;
        regwrite_ex_mem = 1'b0;
        rd_mem_wb       = '0;
        regwrite_mem_wb = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic set_hazard();
        memread_id_ex = 1'b1;
        rd_id_ex      = 5'd7;
        rs_id         = {5'd7, 5'd2};
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        set_hazard();
        rs_ex = {5'd0, 5'd5};
        rd_ex_mem = 5'd5;
        regwrite_ex_mem = 1'b1;
        tick();
        #2;
        if (st1 !== 3'b000) begin
            $display("FAIL reset_stall_lat1 got=%b exp=%b", st1, 3'b000); n_fail++;
        end
        n_checks++;
        if (st3 !== 3'b000) begin
            $display("FAIL reset_stall_lat3 got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        if (cnt3 !== 32'd0) begin
            $display("FAIL reset_cnt got=%0d exp=0", cnt3); n_fail++;
        end
        n_checks++;
        if (fwd1 !== 4'b0001) begin
            $display("FAIL reset_forward_comb got=%b exp=%b", fwd1, 4'b0001); n_fail++;
        end
        n_checks++;
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_forward();
        do_reset();
        rs_ex = {5'd0, 5'd5};
        rd_ex_mem = 5'd5; regwrite_ex_mem = 1'b1;
        rd_mem_wb = 5'd5; regwrite_mem_wb = 1'b1;
        #1;
        if (fwd1 !== 4'b0001) begin
            $display("FAIL fwd_priority got=%b exp=%b", fwd1, 4'b0001); n_fail++;
        end
        n_checks++;
        regwrite_ex_mem = 1'b0;
        #1;
        if (fwd1 !== 4'b0010) begin
            $display("FAIL fwd_memwb got=%b exp=%b", fwd1, 4'b0010); n_fail++;
        end
        n_checks++;
        rd_ex_mem = 5'd0; regwrite_ex_mem = 1'b1;
        rd_mem_wb = 5'd0; regwrite_mem_wb = 1'b1;
        #1;
        if (fwd1 !== 4'b0000) begin
            $display("FAIL fwd_x0 got=%b exp=%b", fwd1, 4'b0000); n_fail++;
        end
        n_checks++;
        rs_ex = {5'd9, 5'd3};
        rd_ex_mem = 5'd9; regwrite_ex_mem = 1'b1;
        rd_mem_wb = 5'd3; regwrite_mem_wb = 1'b1;
        #1;
        if (fwd3 !== 4'b0110) begin
            $display("FAIL fwd_mixed got=%b exp=%b", fwd3, 4'b0110); n_fail++;
        end
        n_checks++;
        regwrite_mem_wb = 1'b0;
        #1;
        if (fwd3 !== 4'b0100) begin
            $display("FAIL fwd_op1_only got=%b exp=%b", fwd3, 4'b0100); n_fail++;
        end
        n_checks++;
        // Full-width compare: 5'd19 differs from 5'd3 only in bit 4.
        rd_ex_mem = 5'd19; regwrite_ex_mem = 1'b1;
        rs_ex = {5'd0, 5'd3};
        #1;
        if (fwd1 !== 4'b0000) begin
            $display("FAIL fwd_fullwidth got=%b exp=%b", fwd1, 4'b0000); n_fail++;
        end
        n_checks++;
        clear_inputs();
    endtask

    task automatic test_no_hazard();
        do_reset();
        rd_id_ex = 5'd7; rs_id = {5'd7, 5'd2}; memread_id_ex = 1'b0;
        #2;
        if (st3 !== 3'b000) begin
            $display("FAIL nohz_not_load got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        rd_id_ex = 5'd0; rs_id = {5'd0, 5'd0}; memread_id_ex = 1'b1;
        #1;
        if (st3 !== 3'b000) begin
            $display("FAIL nohz_x0 got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        rd_id_ex = 5'd7; rs_id = {5'd3, 5'd2};
        #1;
        if (st3 !== 3'b000) begin
            $display("FAIL nohz_nomatch got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        rs_id = {5'd3, 5'd7};
        #1;
        if (st1 !== 3'b111) begin
            $display("FAIL hz_operand0 got=%b exp=%b", st1, 3'b111); n_fail++;
        end
        n_checks++;
        clear_inputs();
    endtask

    task automatic test_stall_lat1();
        do_reset();
        set_hazard();
        #2;
        if (st1 !== 3'b111) begin
            $display("FAIL lat1_stall got=%b exp=%b", st1, 3'b111); n_fail++;
        end
        n_checks++;
        tick();
        clear_inputs();
        #2;
        if (st1 !== 3'b000) begin
            $display("FAIL lat1_release got=%b exp=%b", st1, 3'b000); n_fail++;
        end
        n_checks++;
        if (cnt1 !== (CNT_EN ? 32'd1 : 32'd0)) begin
            $display("FAIL lat1_cnt got=%0d exp=%0d", cnt1, CNT_EN ? 1 : 0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_stall_lat3();
        do_reset();
        set_hazard();
        for (int c = 0; c < 3; c++) begin
            #2;
            if (st3 !== 3'b111) begin
                $display("FAIL lat3_stall_c%0d got=%b exp=%b", c, st3, 3'b111); n_fail++;
            end
            n_checks++;
            tick();
        end
        clear_inputs();
        #2;
        if (st3 !== 3'b000) begin
            $display("FAIL lat3_release got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        if (cnt3 !== (CNT_EN ? 32'd3 : 32'd0)) begin
            $display("FAIL lat3_cnt got=%0d exp=%0d", cnt3, CNT_EN ? 3 : 0); n_fail++;
        end
        n_checks++;
    endtask

    // Hazard removed after the first cycle: the window still runs to three.
    // Then the LOAD_LAT=1 unit sees two consecutive hazards, two stalls.
    task automatic test_back_to_back();
        do_reset();
        set_hazard();
        tick();
        clear_inputs();
        for (int c = 1; c < 3; c++) begin
            #2;
            if (st3 !== 3'b111) begin
                $display("FAIL b2b_window_c%0d got=%b exp=%b", c, st3, 3'b111); n_fail++;
            end
            n_checks++;
            tick();
        end
        #2;
        if (st3 !== 3'b000) begin
            $display("FAIL b2b_window_end got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        do_reset();
        set_hazard();
        tick();
        #2;
        if (st1 !== 3'b111) begin
            $display("FAIL b2b_lat1_second got=%b exp=%b", st1, 3'b111); n_fail++;
        end
        n_checks++;
        tick();
        clear_inputs();
        #2;
        if (cnt1 !== (CNT_EN ? 32'd2 : 32'd0)) begin
            $display("FAIL b2b_lat1_cnt got=%0d exp=%0d", cnt1, CNT_EN ? 2 : 0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_flush();
        do_reset();
        set_hazard();
        flush = 1'b1;
        #2;
        if (st1 !== 3'b000) begin
            $display("FAIL flush_over_hz got=%b exp=%b", st1, 3'b000); n_fail++;
        end
        n_checks++;
        flush = 1'b0;
        #1;
        if (st3 !== 3'b111) begin
            $display("FAIL flush_c1 got=%b exp=%b", st3, 3'b111); n_fail++;
        end
        n_checks++;
        tick();
        flush = 1'b1;
        #2;
        if (st3 !== 3'b000) begin
            $display("FAIL flush_c2 got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        tick();
        clear_inputs();
        #2;
        if (st3 !== 3'b000) begin
            $display("FAIL flush_idle got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        if (cnt3 !== (CNT_EN ? 32'd1 : 32'd0)) begin
            $display("FAIL flush_cnt got=%0d exp=%0d", cnt3, CNT_EN ? 1 : 0); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_hazard();
        #2;
        if (st3 !== 3'b111) begin
            $display("FAIL rstmid_c1 got=%b exp=%b", st3, 3'b111); n_fail++;
        end
        n_checks++;
        tick();
        clear_inputs();
        rst = 1'b1;
        #2;
        if (st3 !== 3'b000) begin
            $display("FAIL rstmid_same_cycle got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        tick();
        rst = 1'b0;
        #2;
        if (st3 !== 3'b000) begin
            $display("FAIL rstmid_idle got=%b exp=%b", st3, 3'b000); n_fail++;
        end
        n_checks++;
        if (cnt3 !== 32'd0) begin
            $display("FAIL rstmid_cnt got=%0d exp=0", cnt3); n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_no_hazard();
        test_stall_lat1();
        test_stall_lat3();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Parametrised forwarding and load-use hazard unit for the 5-stage RISC-V pipeline.
- Forwarding: for each of NUM_SRC source operands of the instruction in EX, selects the EX/MEM result, the MEM/WB result or the register file.
- Hazard detection: finds load-use hazards against the instruction in ID and drives a sequential stall FSM that holds PC/IF-ID and injects bubbles into ID/EX for LOAD_LAT cycles.
- Sits beside the ID/EX stage; its outputs drive the ALU operand muxes and the pipeline register enables.

Parameters:
NUM_SRC, 2, number of source operands per instruction (2 = rs1/rs2, 3 adds rs3)
REG_ADDR_W, 5, register address width
LOAD_LAT, 1, stall cycles per load-use hazard (legal range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rs_id  in  NUM_SRC*REG_ADDR_W  source regs of the instruction in ID; operand i at bits [i*REG_ADDR_W +: REG_ADDR_W]
rs_ex  in  NUM_SRC*REG_ADDR_W  source regs of the instruction in EX; same packing
rd_id_ex  in  REG_ADDR_W  destination reg of the instruction in EX
memread_id_ex  in  1  instruction in EX is a load
rd_ex_mem  in  REG_ADDR_W  destination reg in EX/MEM
regwrite_ex_mem  in  1  EX/MEM writes the register file
rd_mem_wb  in  REG_ADDR_W  destination reg in MEM/WB
regwrite_mem_wb  in  1  MEM/WB writes the register file
flush  in  1  branch/jump redirect; aborts any stall
forward  out  2*NUM_SRC  per-operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB; 11 is never driven
stall_pc  out  1  hold PC
stall_if_id  out  1  hold IF/ID
bubble_id_ex  out  1  load a NOP into ID/EX
stall_cycles  out  32  stall-cycle counter (optional feature)

Behaviour:
Forwarding (combinational, per operand i):
- Operand i forwards from EX/MEM (01) if regwrite_ex_mem=1, rd_ex_mem!=0 and rd_ex_mem==rs_ex[i].
- Otherwise it forwards from MEM/WB (10) if regwrite_mem_wb=1, rd_mem_wb!=0 and rd_mem_wb==rs_ex[i].
- Otherwise 00.
- EX/MEM always has priority over MEM/WB. x0 is never forwarded.

Hazard detect (combinational):
- hz = memread_id_ex & (rd_id_ex!=0) & (rd_id_ex matches any rs_id[i]).

Stall FSM (registered state IDLE/STALL, counter cnt of 4 bits):
- IDLE, hz=1, flush=0: stall outputs assert in the same cycle. If LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-1; otherwise stay in IDLE.
- STALL: stall outputs asserted. cnt decrements each cycle. When cnt==1, the next state is IDLE.
- Stall outputs are stall_pc = stall_if_id = bubble_id_ex = 1. They assert whenever (IDLE & hz & !flush) or (STALL & !flush).
- flush=1 in any state: all stall outputs are 0 that cycle and the next state is IDLE with cnt=0. Flush has priority over hz.
- A new hz seen in STALL is ignored. The stall window is fixed at LOAD_LAT cycles; a bubble in EX cannot create a new hazard.
- Total stall length per hazard is exactly LOAD_LAT cycles.

Reset:
- rst=1: state=IDLE, cnt=0, stall_cycles=0.
- While rst=1, stall outputs are forced to 0. forward stays combinational.
- Reset mid-stall aborts the stall immediately.

Widths:
- Equality compares use the full REG_ADDR_W.
- NUM_SRC >= 1; NUM_SRC generate loops cover all operands.

Optional Feature:
Macro HAZARD_STALL_CNT_EN.
- Defined: stall_cycles is a 32-bit register, cleared on rst, incremented on every cycle in which stall_pc=1. It saturates at 0xFFFFFFFF; it does not wrap.
- Undefined: stall_cycles is tied to 0 and no counter flops exist.

Test Plan:
- rs_ex[0]=5; rd_ex_mem=5 and rd_mem_wb=5, both regwrite=1 -> forward[1:0]=01 (priority). Set regwrite_ex_mem=0 -> 10.
- rd_ex_mem=0 with regwrite_ex_mem=1; rs_ex[1]=0 -> forward[3:2]=00.
- LOAD_LAT=1, memread_id_ex=1, rd_id_ex=7, rs_id[1]=7 -> stall_pc/stall_if_id/bubble_id_ex=1 for exactly 1 cycle. stall_cycles increments by 1 (macro on).
- LOAD_LAT=3, same hazard held for 3 cycles -> stall outputs high for exactly 3 cycles, then 0. stall_cycles=3.
- LOAD_LAT=3, flush=1 on the 2nd stall cycle -> stall outputs 0 that cycle, FSM in IDLE next cycle. stall_cycles=1.
- rst=1 asserted during STALL -> outputs 0 the same cycle. After release, FSM is in IDLE and stall_cycles=0.
